// File: rtl/d8_pkg.sv
// d8_pkg: shared types and constants for the d8 memory subsystem
// (FSM state encoding, requester port indices, default address/data widths).
package d8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } d8_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int D8_AW = 8;
    localparam int D8_DW = 8;

endpackage

// File: rtl/d8_rr_pick.sv
// d8_rr_pick: combinational two-way selector, round-robin against last_grant
// or fixed priority to port 0 when fixed_prio is set.
module d8_rr_pick
    import d8_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant
);

    // With no request the output is a don't-care; PORT_CPU keeps it defined.
    always_comb begin
        grant = PORT_CPU;
        if (req == 2'b11) begin
            grant = fixed_prio ? PORT_CPU : ~last_grant;
        end else if (req[1]) begin
            grant = PORT_DBG;
        end
    end

endmodule

// File: rtl/d8_mem_arb.sv
// d8_mem_arb: two-requester arbiter in front of the single-port d8 memory.
// Define D8_MEM_ARB_LOCK_EN to add m0_lock/m1_lock ownership holding.
module d8_mem_arb
    import d8_pkg::*;
#(
    parameter int AW         = D8_AW,
    parameter int DW         = D8_DW,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
`ifdef D8_MEM_ARB_LOCK_EN
    input  logic          m0_lock,
`endif
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
`ifdef D8_MEM_ARB_LOCK_EN
    input  logic          m1_lock,
`endif
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata and holds them all
    // stable until it sees its one-cycle ack; req still high after ack is a new request.

    d8_state_e     state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          xlock_q, xlock_d;
    logic          en_d, we_d, ack0_d, ack1_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [1:0]    req_v;
    logic          rr_grant, go, pick, skip_arb;

    assign req_v = {m1_req, m0_req};

    d8_rr_pick u_pick (
        .req        (req_v),
        .last_grant (last_q),
        .fixed_prio (FIXED_PRIO),
        .grant      (rr_grant)
    );

`ifdef D8_MEM_ARB_LOCK_EN
    logic hold_q;

    // Owner's lock is sampled at the end of its RESP cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_q <= 1'b0;
        end else if (state_q == ST_RESP) begin
            hold_q <= (owner_q == PORT_DBG) ? m1_lock : m0_lock;
        end
    end

    assign go       = hold_q ? req_v[owner_q] : (|req_v);
    assign pick     = hold_q ? owner_q : rr_grant;
    assign skip_arb = hold_q;
`else
    assign go       = |req_v;
    assign pick     = rr_grant;
    assign skip_arb = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        xlock_d = xlock_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    owner_d = pick;
                    xlock_d = skip_arb;
                    en_d    = 1'b1;
                    we_d    = (pick == PORT_DBG) ? m1_we    : m0_we;
                    addr_d  = (pick == PORT_DBG) ? m1_addr  : m0_addr;
                    wdata_d = (pick == PORT_DBG) ? m1_wdata : m0_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Locked follow-on transfers leave the round-robin pointer alone.
                if (!xlock_q) begin
                    last_d = owner_q;
                end
                ack0_d  = (owner_q == PORT_CPU);
                ack1_d  = (owner_q == PORT_DBG);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q == PORT_DBG) begin
                    rd1_d = mem_rdata;
                end else begin
                    rd0_d = mem_rdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT_CPU;
            last_q    <= PORT_DBG;
            xlock_q   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            xlock_q   <= xlock_d;
            mem_en    <= en_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            m0_ack    <= ack0_d;
            m1_ack    <= ack1_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    // The memory's own output register supplies rdata during the ack cycle;
    // the captured copy holds it afterwards.
    assign m0_rdata  = m0_ack ? mem_rdata : rd0_q;
    assign m1_rdata  = m1_ack ? mem_rdata : rd1_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_d8_mem_arb.sv
// tb_d8_mem_arb: directed and randomized checks of d8_mem_arb against a
// transaction-level reference (expected memory image and round-robin order).
module tb_d8_mem_arb;
    import d8_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       m0_req = 1'b0, m0_we = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0;
    logic       m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m1_addr = '0, m1_wdata = '0;
    logic       m0_lock = 1'b0, m1_lock = 1'b0;
    logic       m0_ack, m1_ack, mem_en, mem_we;
    logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [1:0] dbg_state;
    logic       f_m0_ack, f_m1_ack, f_mem_en, f_mem_we;
    logic [7:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
    logic [7:0] f_mem_rdata = '0;
    logic [1:0] f_dbg_state;

    logic [7:0] mem [256];
    logic [7:0] fmem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] seed;
    logic       mem_init = 1'b1;
    logic       rr_last;
    logic       win, fwin;
    logic [7:0] aa0, aa1, ra, wa, wd;
    logic [7:0] la [3];
    logic [7:0] ld [3];
    int         tests = 0;
    int         fails = 0;

    always #5 sys_clk = ~sys_clk;

    d8_mem_arb #(.AW(8), .DW(8), .FIXED_PRIO(1'b0)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef D8_MEM_ARB_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef D8_MEM_ARB_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    d8_mem_arb #(.AW(8), .DW(8), .FIXED_PRIO(1'b1)) u_fp (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef D8_MEM_ARB_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef D8_MEM_ARB_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .dbg_state(f_dbg_state)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 'h10) return 8'hA5;
        return 8'(i * 37) ^ seed;
    endfunction

    // 256x8 synchronous-read memories; a read during write returns the old word.
    always @(posedge sys_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    always @(posedge sys_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) fmem[i] <= init_val(i);
        end else if (f_mem_en) begin
            if (f_mem_we) fmem[f_mem_addr] <= f_mem_wdata;
            f_mem_rdata <= fmem[f_mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m0_ack"}, m0_ack, 0);
        chk({tag, "_m1_ack"}, m1_ack, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // One access on a single port with the other idle; checks every cycle of it.
    task automatic single(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        set_port(p, 1'b1, we, a, d);
        tick();
        chk("iss_en", mem_en, 1);
        chk("iss_addr", mem_addr, a);
        chk("iss_we", mem_we, we);
        chk("iss_state", dbg_state, ST_ISSUE);
        chk("iss_noack", m0_ack | m1_ack, 0);
        if (we) chk("iss_wdata", mem_wdata, d);
        tick();
        chk("resp_en", mem_en, 0);
        chk("resp_we", mem_we, 0);
        chk("ack_owner", (p == 1) ? m1_ack : m0_ack, 1);
        chk("ack_other", (p == 1) ? m0_ack : m1_ack, 0);
        if (!we) chk("rdata", (p == 1) ? m1_rdata : m0_rdata, ref_mem[a]);
        else ref_mem[a] = d;
        rr_last = (p == 1);
        set_port(p, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("ack_clear", m0_ack | m1_ack, 0);
    endtask

    // Random one- or two-port round: both ports hold req until their ack.
    task automatic rand_round();
        logic [1:0] rq;
        logic       we_v [2];
        logic [7:0] a_v [2];
        logic [7:0] d_v [2];
        int         t_v [2];
        logic       first;
        rq = 2'($urandom_range(1, 3));
        for (int p = 0; p < 2; p++) begin
            we_v[p] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a_v[p] = 8'hFF;
                1: a_v[p] = 8'h00;
                default: a_v[p] = 8'($urandom_range(0, 255));
            endcase
            d_v[p] = 8'($urandom);
            t_v[p] = 0;
        end
        first = (rq == 2'b11) ? ~rr_last : rq[1];
        t_v[first] = 2;
        if (rq == 2'b11) t_v[!first] = 5;
        set_port(0, rq[0], we_v[0], a_v[0], d_v[0]);
        set_port(1, rq[1], we_v[1], a_v[1], d_v[1]);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("rnd_ack0", m0_ack, (c == t_v[0]));
            chk("rnd_ack1", m1_ack, (c == t_v[1]));
            for (int p = 0; p < 2; p++) begin
                if (c == t_v[p]) begin
                    if (!we_v[p]) chk("rnd_rdata", (p == 1) ? m1_rdata : m0_rdata, ref_mem[a_v[p]]);
                    else ref_mem[a_v[p]] = d_v[p];
                    rr_last = (p == 1);
                    set_port(p, 1'b0, 1'b0, 8'h00, 8'h00);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        seed = 8'($urandom);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rr_last = 1'b1;
        sys_rst = 1'b1;
        mem_init = 1'b1;
        repeat (2) tick();
        mem_init = 1'b0;
        chk_reset_outputs("reset");
        sys_rst = 1'b0;

        // Preloaded read at 0x10, then boundary write/read at 0xFF.
        single(0, 1'b0, 8'h10, 8'h00);
        chk("rd10_const", m0_rdata, 8'hA5);
        single(1, 1'b1, 8'hFF, 8'h3C);
        single(0, 1'b0, 8'hFF, 8'h00);
        chk("rdff_const", m0_rdata, 8'h3C);

        // Both ports request continuously; port 0 drops after slot at cycle 11.
        aa0 = 8'($urandom);
        aa1 = 8'($urandom);
        set_port(0, 1'b1, 1'b0, aa0, 8'h00);
        set_port(1, 1'b1, 1'b0, aa1, 8'h00);
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c >= 2 && (c - 2) % 3 == 0) begin
                win  = (c <= 11) ? ~rr_last : 1'b1;
                fwin = (c <= 11) ? 1'b0 : 1'b1;
                rr_last = win;
                chk("alt_ack0", m0_ack, !win);
                chk("alt_ack1", m1_ack, win);
                chk("alt_rdata", win ? m1_rdata : m0_rdata, win ? ref_mem[aa1] : ref_mem[aa0]);
                chk("fp_ack0", f_m0_ack, !fwin);
                chk("fp_ack1", f_m1_ack, fwin);
                chk("fp_rdata", fwin ? f_m1_rdata : f_m0_rdata, fwin ? ref_mem[aa1] : ref_mem[aa0]);
            end else begin
                chk("alt_idle", {m1_ack, m0_ack}, 0);
                chk("fp_idle", {f_m1_ack, f_m0_ack}, 0);
            end
            if (c == 11) set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Reset during the ISSUE cycle of a port 1 read.
        ra = 8'($urandom);
        set_port(1, 1'b1, 1'b0, ra, 8'h00);
        tick();
        chk("rst_iss_state", dbg_state, ST_ISSUE);
        sys_rst = 1'b1;
        tick();
        chk_reset_outputs("rst_mid");
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
        sys_rst = 1'b0;
        rr_last = 1'b1;
        tick();
        chk("rst_noack", m1_ack, 0);
        single(1, 1'b0, ra, 8'h00);

        // A write already strobed when reset arrives still lands.
        wa = 8'($urandom);
        wd = ~ref_mem[wa];
        set_port(0, 1'b1, 1'b1, wa, wd);
        tick();
        chk("rstw_en", mem_en, 1);
        sys_rst = 1'b1;
        tick();
        chk("rstw_noack", m0_ack, 0);
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
        sys_rst = 1'b0;
        rr_last = 1'b1;
        ref_mem[wa] = wd;
        single(0, 1'b0, wa, 8'h00);

        for (int r = 0; r < 40; r++) rand_round();

`ifdef D8_MEM_ARB_LOCK_EN
        // Port 1 holds the memory for three writes while port 0 waits.
        single(0, 1'b0, 8'h20, 8'h00);
        la[0] = 8'h30; la[1] = 8'h31; la[2] = 8'hFF;
        for (int k = 0; k < 3; k++) ld[k] = 8'($urandom);
        m1_lock = 1'b1;
        set_port(0, 1'b1, 1'b0, la[2], 8'h00);
        set_port(1, 1'b1, 1'b1, la[0], ld[0]);
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk("lock_ack1", m1_ack, (c == 2 || c == 5 || c == 8));
            chk("lock_ack0", m0_ack, (c == 11));
            if (c == 2) set_port(1, 1'b1, 1'b1, la[1], ld[1]);
            if (c == 5) set_port(1, 1'b1, 1'b1, la[2], ld[2]);
            if (c == 6) m1_lock = 1'b0;
            if (c == 8) set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
            if (c == 11) begin
                chk("lock_rdata", m0_rdata, ld[2]);
                set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        for (int k = 0; k < 3; k++) ref_mem[la[k]] = ld[k];
        single(1, 1'b0, la[0], 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
